// File: rtl/craft_round_if.sv
// Handshake and strobe bundle between the CRAFT round sequencer and its users.
// The master side requests encryptions and watches the phase strobes; the
// slave side is the sequencer itself.
interface craft_round_if;
   logic       start;
   logic       ready;
   logic       busy;
   logic       load_en;
   logic [7:0] r;
   logic       en;
   logic       ck0;
   logic [3:0] nib_idx;
   logic       sbox_en;
   logic       out_valid;
   logic       done;

   modport master (
      output start,
      input  ready, busy, load_en, r, en, ck0, nib_idx, sbox_en, out_valid, done
   );

   modport slave (
      input  start,
      output ready, busy, load_en, r, en, ck0, nib_idx, sbox_en, out_valid, done
   );
endinterface

// File: rtl/craft_round_ctrl.sv
// CRAFT round sequencer: walks one encryption through a 16-nibble load,
// NUM_ROUNDS rounds of 16 nibbles, and a 16-nibble unload, driving the key
// register (r / en / ck0) and the state datapath phase strobes.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; ready=1
// LOAD    | shifting in plaintext nibble nib_idx
// ROUND   | full round r (sbox on), r = 0 .. NUM_ROUNDS-2
// LAST    | final round r = NUM_ROUNDS-1, linear layer + key add only
// UNLOAD  | ciphertext nibble nib_idx valid on datapath output
// DONE    | one-cycle completion pulse, then back to IDLE
module craft_round_ctrl #(
   parameter int NUM_ROUNDS = 32,
   parameter int NIBBLES    = 16
) (
   input  logic         clk,
   input  logic         rst,
   craft_round_if.slave bus
);

   if (NUM_ROUNDS < 2 || NUM_ROUNDS > 255) begin : g_bad_rounds
      $error("craft_round_ctrl: NUM_ROUNDS must be in 2..255");
   end
   if (NIBBLES != 16) begin : g_bad_nibbles
      $error("craft_round_ctrl: NIBBLES is fixed at 16 for CRAFT");
   end

   localparam logic [7:0] LAST_R   = 8'(NUM_ROUNDS - 1);
   localparam logic [3:0] NIB_LAST = 4'(NIBBLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_ROUND  = 3'd2,
      S_LAST   = 3'd3,
      S_UNLOAD = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] nib_q, nib_d;
   logic [7:0] r_q, r_d;
   logic [7:0] r_inc;
   logic       last_nib;

   assign last_nib = (nib_q == NIB_LAST);
   assign r_inc    = r_q + 8'd1;

   // State, nibble counter and round counter registers; reset aborts any run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         nib_q   <= 4'd0;
         r_q     <= 8'd0;
      end else begin
         state_q <= state_d;
         nib_q   <= nib_d;
         r_q     <= r_d;
      end
   end

   // Next-state logic; r only moves on the nibble 15 -> 0 boundary so the key
   // register sees a stable round index for a whole round.
   always_comb begin
      state_d = state_q;
      nib_d   = nib_q;
      r_d     = r_q;
      unique case (state_q)
         S_IDLE: begin
            nib_d = 4'd0;
            r_d   = 8'd0;
            if (bus.start) state_d = S_LOAD;
         end
         S_LOAD: begin
            nib_d = nib_q + 4'd1;
            if (last_nib) begin
               state_d = S_ROUND;
               r_d     = 8'd0;
            end
         end
         S_ROUND: begin
            nib_d = nib_q + 4'd1;
            if (last_nib) begin
               r_d = r_inc;
               if (r_inc == LAST_R) state_d = S_LAST;
            end
         end
         S_LAST: begin
            nib_d = nib_q + 4'd1;
            if (last_nib) begin
               state_d = S_UNLOAD;
               r_d     = 8'd0;
            end
         end
         S_UNLOAD: begin
            nib_d = nib_q + 4'd1;
            if (last_nib) state_d = S_DONE;
         end
         S_DONE: begin
            nib_d   = 4'd0;
            r_d     = 8'd0;
            state_d = S_IDLE;
         end
         default: begin
            nib_d   = 4'd0;
            r_d     = 8'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore output decode from registered state and counters only.
   always_comb begin
      bus.ready     = 1'b0;
      bus.busy      = 1'b0;
      bus.load_en   = 1'b0;
      bus.en        = 1'b0;
      bus.r         = 8'd0;
      bus.ck0       = 1'b0;
      bus.nib_idx   = nib_q;
      bus.sbox_en   = 1'b0;
      bus.out_valid = 1'b0;
      bus.done      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            bus.ready   = 1'b1;
            bus.nib_idx = 4'd0;
         end
         S_LOAD: begin
            bus.busy    = 1'b1;
            bus.load_en = 1'b1;
         end
         S_ROUND: begin
            bus.busy    = 1'b1;
            bus.en      = 1'b1;
            bus.r       = r_q;
            bus.ck0     = (nib_q == 4'd0);
            bus.sbox_en = 1'b1;
         end
         S_LAST: begin
            bus.busy = 1'b1;
            bus.en   = 1'b1;
            bus.r    = r_q;
            bus.ck0  = (nib_q == 4'd0);
         end
         S_UNLOAD: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
         end
         S_DONE: begin
            bus.done    = 1'b1;
            bus.nib_idx = 4'd0;
         end
         default: begin
            bus.nib_idx = 4'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_craft_round_ctrl.sv
// Bench for craft_round_ctrl: a default 32-round instance and a 2-round
// instance. Stimulus pushes the expected per-cycle output vector of each run
// (from the documented timeline) into a queue; a negedge monitor pops and
// compares whenever a vector is due, and otherwise expects a quiet IDLE.
module tb_craft_round_ctrl;

   typedef struct {
      int         cyc;
      logic       ready;
      logic       busy;
      logic       load_en;
      logic [7:0] r;
      logic       en;
      logic       ck0;
      logic [3:0] nib;
      logic       sbox;
      logic       ov;
      logic       done;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   vec_t q_a[$];
   vec_t q_b[$];

   int cnt_load = 0, cnt_en = 0, cnt_ck0 = 0, cnt_nosbox = 0, cnt_ov = 0, cnt_done = 0;

   craft_round_if bus_a ();
   craft_round_if bus_b ();

   craft_round_ctrl #(.NUM_ROUNDS(32), .NIBBLES(16)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   craft_round_ctrl #(.NUM_ROUNDS(2), .NIBBLES(16)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected outputs on run cycle k (k=1 is the first LOAD cycle).
   function automatic vec_t exp_at(input int base, input int k, input int nr);
      vec_t e;
      int   j;
      e.cyc = base + k;
      e.ready = 1'b0; e.busy = 1'b0; e.load_en = 1'b0; e.r = 8'd0; e.en = 1'b0;
      e.ck0 = 1'b0; e.nib = 4'd0; e.sbox = 1'b0; e.ov = 1'b0; e.done = 1'b0;
      if (k <= 16) begin
         e.busy = 1'b1; e.load_en = 1'b1; e.nib = 4'(k - 1);
      end else if (k <= 16 + 16 * nr) begin
         j = k - 17;
         e.busy = 1'b1; e.en = 1'b1;
         e.r    = 8'(j / 16);
         e.nib  = 4'(j % 16);
         e.ck0  = ((j % 16) == 0);
         e.sbox = ((j / 16) < nr - 1);
      end else if (k <= 32 + 16 * nr) begin
         e.busy = 1'b1; e.ov = 1'b1; e.nib = 4'(k - 17 - 16 * nr);
      end else begin
         e.done = 1'b1;
      end
      return e;
   endfunction

   task automatic cmp_vec(input string tag, input vec_t a, input vec_t e);
      chk({tag, ".ready"},     int'(a.ready),   int'(e.ready));
      chk({tag, ".busy"},      int'(a.busy),    int'(e.busy));
      chk({tag, ".load_en"},   int'(a.load_en), int'(e.load_en));
      chk({tag, ".r"},         int'(a.r),       int'(e.r));
      chk({tag, ".en"},        int'(a.en),      int'(e.en));
      chk({tag, ".ck0"},       int'(a.ck0),     int'(e.ck0));
      chk({tag, ".nib_idx"},   int'(a.nib),     int'(e.nib));
      chk({tag, ".sbox_en"},   int'(a.sbox),    int'(e.sbox));
      chk({tag, ".out_valid"}, int'(a.ov),      int'(e.ov));
      chk({tag, ".done"},      int'(a.done),    int'(e.done));
   endtask

   task automatic push_a(input int base);
      for (int k = 1; k <= 33 + 16 * 32; k++) q_a.push_back(exp_at(base, k, 32));
   endtask

   task automatic push_b(input int base);
      for (int k = 1; k <= 33 + 16 * 2; k++) q_b.push_back(exp_at(base, k, 2));
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor for the 32-round instance.
   always @(negedge clk) begin
      vec_t a, e;
      a.cyc = cyc; a.ready = bus_a.ready; a.busy = bus_a.busy; a.load_en = bus_a.load_en;
      a.r = bus_a.r; a.en = bus_a.en; a.ck0 = bus_a.ck0; a.nib = bus_a.nib_idx;
      a.sbox = bus_a.sbox_en; a.ov = bus_a.out_valid; a.done = bus_a.done;
      if (q_a.size() > 0 && q_a[0].cyc == cyc) begin
         e = q_a.pop_front();
         cmp_vec("A", a, e);
      end else if (a.busy || a.done) begin
         chk("A.unexpected_activity", 1, 0);
      end else begin
         chk("A.idle_ready", int'(a.ready), 1);
         chk("A.idle_en", int'(a.en), 0);
         chk("A.idle_r", int'(a.r), 0);
         chk("A.idle_nib", int'(a.nib), 0);
      end
      if (a.load_en) cnt_load++;
      if (a.en) cnt_en++;
      if (a.ck0) cnt_ck0++;
      if (a.en && !a.sbox) cnt_nosbox++;
      if (a.ov) cnt_ov++;
      if (a.done) cnt_done++;
   end

   // Monitor for the 2-round instance.
   always @(negedge clk) begin
      vec_t a, e;
      a.cyc = cyc; a.ready = bus_b.ready; a.busy = bus_b.busy; a.load_en = bus_b.load_en;
      a.r = bus_b.r; a.en = bus_b.en; a.ck0 = bus_b.ck0; a.nib = bus_b.nib_idx;
      a.sbox = bus_b.sbox_en; a.ov = bus_b.out_valid; a.done = bus_b.done;
      if (q_b.size() > 0 && q_b[0].cyc == cyc) begin
         e = q_b.pop_front();
         cmp_vec("B", a, e);
      end else if (a.busy || a.done) begin
         chk("B.unexpected_activity", 1, 0);
      end else begin
         chk("B.idle_ready", int'(a.ready), 1);
         chk("B.idle_r", int'(a.r), 0);
      end
   end

   initial begin
      int base;
      int s_load, s_en, s_ck0, s_nosbox, s_ov, s_done;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;

      // Reset then idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      s_done = cnt_done;
      repeat (50) @(posedge clk);
      #1;
      chk("T1.done_count", cnt_done - s_done, 0);

      // Full run with an ignored start pulse at cycle 100
      @(posedge clk);
      #1;
      base = cyc;
      push_a(base);
      s_load = cnt_load; s_en = cnt_en; s_ck0 = cnt_ck0;
      s_nosbox = cnt_nosbox; s_ov = cnt_ov; s_done = cnt_done;
      bus_a.start = 1'b1;
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      wait_cyc(base + 99);
      bus_a.start = 1'b1;
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      wait_cyc(base + 548);
      chk("T2.load_en_cycles", cnt_load - s_load, 16);
      chk("T2.en_cycles", cnt_en - s_en, 512);
      chk("T2.ck0_count", cnt_ck0 - s_ck0, 32);
      chk("T3.sbox_off_cycles", cnt_nosbox - s_nosbox, 16);
      chk("T3.out_valid_cycles", cnt_ov - s_ov, 16);
      chk("T2.done_count", cnt_done - s_done, 1);

      // start held high: done at 545, one IDLE cycle, next LOAD at 547
      @(posedge clk);
      #1;
      base = cyc;
      push_a(base);
      push_a(base + 546);
      bus_a.start = 1'b1;
      wait_cyc(base + 547);
      bus_a.start = 1'b0;
      wait_cyc(base + 546 + 548);

      // Async abort at round 7 nibble 5
      @(posedge clk);
      #1;
      base = cyc;
      push_a(base);
      bus_a.start = 1'b1;
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      wait_cyc(base + 134);
      @(negedge clk);
      #1;
      chk("T5.pre_abort_r", int'(bus_a.r), 7);
      chk("T5.pre_abort_nib", int'(bus_a.nib_idx), 5);
      rst = 1'b1;
      q_a.delete();
      #1;
      chk("T5.abort_ready", int'(bus_a.ready), 1);
      chk("T5.abort_busy", int'(bus_a.busy), 0);
      chk("T5.abort_en", int'(bus_a.en), 0);
      chk("T5.abort_r", int'(bus_a.r), 0);
      chk("T5.abort_nib", int'(bus_a.nib_idx), 0);
      chk("T5.abort_done", int'(bus_a.done), 0);
      chk("T5.abort_sbox", int'(bus_a.sbox_en), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      base = cyc;
      push_a(base);
      s_done = cnt_done;
      bus_a.start = 1'b1;
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      wait_cyc(base + 548);
      chk("T5.clean_run_done_count", cnt_done - s_done, 1);

      // NUM_ROUNDS=2 instance: done on cycle 65
      @(posedge clk);
      #1;
      base = cyc;
      push_b(base);
      bus_b.start = 1'b1;
      @(posedge clk);
      #1;
      bus_b.start = 1'b0;
      wait_cyc(base + 68);

      chk("A.queue_drained", q_a.size(), 0);
      chk("B.queue_drained", q_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
